// File: rtl/ltl_mon_pkg.sv
// ltl_mon_pkg
// Shared types and limits for the table-driven LTL monitor automaton.
//   start_type_e : per-STE start behaviour (code 3 is reserved, acts as NONE)
//   MAX_N_STATES : upper bound on the STE count
//   MAX_SYM_W    : upper bound on the symbol width
//   evt_width()  : width of one event-FIFO entry (report vector, plus the
//                  symbol index when the timestamp build is selected)
package ltl_mon_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        SOD  = 2'd1,
        ALL  = 2'd2
    } start_type_e;

    localparam int MAX_N_STATES = 64;
    localparam int MAX_SYM_W    = 10;

    function automatic int evt_width(int n_states, int idx_w, bit ts_en);
        return n_states + (ts_en ? idx_w : 0);
    endfunction

endpackage

// File: rtl/ltl_monitor_automaton_if.sv
// ltl_monitor_automaton_if
// Report-event drain port (valid/ready).
//   evt_valid  : FIFO head valid            (master -> slave)
//   evt_ready  : consumer accepts the head  (slave -> master)
//   evt_report : head report vector         (master -> slave)
//   evt_idx    : head symbol index, only when LTL_MON_TIMESTAMP_EN is defined
interface ltl_monitor_automaton_if #(
    parameter int N_STATES = 11
`ifdef LTL_MON_TIMESTAMP_EN
    ,
    parameter int IDX_W = 32
`endif
);
    logic                evt_valid;
    logic                evt_ready;
    logic [N_STATES-1:0] evt_report;
`ifdef LTL_MON_TIMESTAMP_EN
    logic [IDX_W-1:0]    evt_idx;

    modport master (output evt_valid, output evt_report, output evt_idx, input evt_ready);
    modport slave  (input evt_valid, input evt_report, input evt_idx, output evt_ready);
`else
    modport master (output evt_valid, output evt_report, input evt_ready);
    modport slave  (input evt_valid, input evt_report, output evt_ready);
`endif
endinterface

// File: rtl/ltl_mon_evt_fifo.sv
// ltl_mon_evt_fifo
// Synchronous event FIFO: drop-on-full push, valid/ready pop, sticky overflow.
//   clk, reset : clock, asynchronous active-high reset (clears pointers)
//   push       : request to enqueue push_data
//   push_data  : entry to enqueue
//   pop_ready  : consumer accepts the head when valid
//   valid      : FIFO not empty (registered pointers only, no bypass)
//   head       : oldest entry
//   overflow   : set when a push is dropped because the FIFO is full
module ltl_mon_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         valid,
    output logic [W-1:0] head,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         pop;
    logic         wr_en;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && pop_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en = push && (!full || pop);

    assign valid = !empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ltl_monitor_automaton.sv
// ltl_monitor_automaton
// Table-driven homogeneous NFA (STE array) over a SYM_W-bit symbol stream,
// with sticky report vector and a report-event FIFO.
// Build option: LTL_MON_TIMESTAMP_EN adds the run-gated symbol index, stores
// it with each event and exposes it as evt.evt_idx.
//   clk          : clock
//   reset        : asynchronous active-high reset
//   run          : symbol valid; the automaton advances only when high
//   symbols      : current symbol
//   active_state : registered STE activity
//   report       : active_state & REPORT
//   sticky       : OR of all report values since reset
//   overflow     : sticky, an event was dropped on a full FIFO
//   evt          : event drain port (master side)
module ltl_monitor_automaton
    import ltl_mon_pkg::*;
#(
    parameter int                                 N_STATES   = 11,
    parameter int                                 SYM_W      = 8,
    parameter logic [N_STATES-1:0][N_STATES-1:0]  ADJ        = '0,
    parameter logic [N_STATES-1:0][2**SYM_W-1:0]  CLASS      = '1,
    parameter logic [N_STATES-1:0][1:0]           START      = '0,
    parameter logic [N_STATES-1:0]                REPORT     = '0,
    parameter int                                 FIFO_DEPTH = 4,
    parameter int                                 IDX_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [SYM_W-1:0]        symbols,
    output logic [N_STATES-1:0]     active_state,
    output logic [N_STATES-1:0]     report,
    output logic [N_STATES-1:0]     sticky,
    output logic                    overflow,
    ltl_monitor_automaton_if.master evt
);
`ifdef LTL_MON_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam int EVT_W = evt_width(N_STATES, IDX_W, TS_EN);

    logic [N_STATES-1:0] nxt;
    logic [N_STATES-1:0] nxt_rep;
    logic                sod;
    logic                push;
    logic [EVT_W-1:0]    push_data;
    logic [EVT_W-1:0]    fifo_head;

    for (genvar i = 0; i < N_STATES; i++) begin : g_ste
        // Reserved code 3 matches neither SOD nor ALL, so it behaves as NONE.
        localparam start_type_e ST = start_type_e'(START[i]);
        assign nxt[i] = CLASS[i][symbols] &
                        ((|(ADJ[i] & active_state)) | ((ST == SOD) & sod) | (ST == ALL));
    end

    assign nxt_rep = nxt & REPORT;
    assign report  = active_state & REPORT;
    assign push    = run && (|nxt_rep);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_state <= '0;
            sticky       <= '0;
            sod          <= 1'b1;
        end else if (run) begin
            active_state <= nxt;
            sticky       <= sticky | nxt_rep;
            sod          <= 1'b0;
        end
    end

`ifdef LTL_MON_TIMESTAMP_EN
    logic [IDX_W-1:0] idx;

    // idx names the symbol being consumed on this edge; first symbol is 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= '0;
        else if (run)
            idx <= idx + IDX_W'(1);
    end

    assign push_data   = {nxt_rep, idx};
    assign evt.evt_idx = fifo_head[IDX_W-1:0];
`else
    assign push_data   = nxt_rep;
`endif

    assign evt.evt_report = fifo_head[EVT_W-1 -: N_STATES];

    ltl_mon_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_evt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop_ready (evt.evt_ready),
        .valid     (evt.evt_valid),
        .head      (fifo_head),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_ltl_monitor_automaton.sv
// Bench automaton (4 STEs):
//   chain A: state 0 (start-of-data, symbol 0x00) -> state 1 (symbol 0x20, reports)
//   chain B: state 2 (all-input,     symbol 0x40) -> state 3 (symbol 0x60, reports)
module tb_ltl_monitor_automaton;
    localparam int N     = 4;
    localparam int SYM_W = 8;
    localparam int DEPTH = 4;
`ifdef LTL_MON_TIMESTAMP_EN
    localparam int IDX_W = 32;
`endif

    localparam logic [N-1:0][N-1:0] P_ADJ   = 16'h4010;
    localparam logic [N-1:0][255:0] P_CLASS = {(256'd1 << 8'h60), (256'd1 << 8'h40),
                                               (256'd1 << 8'h20), 256'd1};
    localparam logic [N-1:0][1:0]   P_START = {2'd0, 2'd2, 2'd0, 2'd1};
    localparam logic [N-1:0]        P_REPORT = 4'b1010;

    // Reference model description, written as sets rather than bit tables.
    int unsigned m_sym[N]   = '{8'h00, 8'h20, 8'h40, 8'h60};
    int          m_start[N] = '{1, 0, 2, 0};
    bit          m_rep[N]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    int          e_src[2]   = '{0, 2};
    int          e_dst[2]   = '{1, 3};

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [SYM_W-1:0] symbols;
    logic [N-1:0]     active_state;
    logic [N-1:0]     report;
    logic [N-1:0]     sticky;
    logic             overflow;

`ifdef LTL_MON_TIMESTAMP_EN
    ltl_monitor_automaton_if #(.N_STATES(N), .IDX_W(IDX_W)) evt ();
`else
    ltl_monitor_automaton_if #(.N_STATES(N)) evt ();
`endif

    always #5 clk = ~clk;

    ltl_monitor_automaton #(
        .N_STATES   (N),
        .SYM_W      (SYM_W),
        .ADJ        (P_ADJ),
        .CLASS      (P_CLASS),
        .START      (P_START),
        .REPORT     (P_REPORT),
`ifdef LTL_MON_TIMESTAMP_EN
        .IDX_W      (IDX_W),
`endif
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .symbols      (symbols),
        .active_state (active_state),
        .report       (report),
        .sticky       (sticky),
        .overflow     (overflow),
        .evt          (evt)
    );

    typedef struct {
        logic [N-1:0] rep;
        int unsigned  idx;
    } evt_t;

    evt_t         exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    bit           mon_en   = 1'b0;

    // Model state (after the edge being prepared) and the currently visible copy.
    bit [N-1:0]   m_act;
    bit [N-1:0]   m_sticky;
    bit           m_sod;
    bit           m_ovf;
    int unsigned  m_idx;
    int           m_cnt;
    bit [N-1:0]   cur_act;
    bit [N-1:0]   cur_sticky;
    bit           cur_ovf;
    int           cur_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [N-1:0] rep_mask();
        bit [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = m_rep[i];
        return m;
    endfunction

    task automatic model_reset();
        m_act = '0; m_sticky = '0; m_sod = 1'b1; m_ovf = 1'b0; m_idx = 0; m_cnt = 0;
        cur_act = '0; cur_sticky = '0; cur_ovf = 1'b0; cur_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit r, input int unsigned s, input bit rdy);
        bit         pop;
        bit [N-1:0] nxt;
        bit [N-1:0] rv;
        bit         en;
        pop = (m_cnt > 0) && rdy;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                en = (m_start[i] == 2) || (m_start[i] == 1 && m_sod);
                for (int e = 0; e < 2; e++)
                    if (e_dst[e] == i && m_act[e_src[e]]) en = 1'b1;
                nxt[i] = en && (s == m_sym[i]);
            end
            rv = nxt & rep_mask();
            m_sticky |= rv;
            if (rv != 0) begin
                if (m_cnt == DEPTH && !pop) begin
                    m_ovf = 1'b1;
                end else begin
                    exp_q.push_back('{rep: rv, idx: m_idx});
                    m_cnt++;
                end
            end
            m_act = nxt;
            m_idx++;
            m_sod = 1'b0;
        end
        if (pop) m_cnt--;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input bit r, input logic [7:0] s, input bit rdy);
        run = r; symbols = s; evt.evt_ready = rdy;
        model_edge(r, s, rdy);
        @(posedge clk); #1;
        cur_act = m_act; cur_sticky = m_sticky; cur_ovf = m_ovf; cur_cnt = m_cnt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: compares visible outputs and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        evt_t e;
        if (mon_en) begin
            chk("active_state", active_state, cur_act);
            chk("report", report, cur_act & rep_mask());
            chk("sticky", sticky, cur_sticky);
            chk("overflow", overflow, cur_ovf);
            chk("evt_valid", evt.evt_valid, cur_cnt > 0);
            if (evt.evt_valid && evt.evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL evt_unexpected actual=%0h expected=no event at %0t",
                             evt.evt_report, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_report", evt.evt_report, e.rep);
`ifdef LTL_MON_TIMESTAMP_EN
                    chk("evt_idx", evt.evt_idx, e.idx);
`endif
                end
            end
        end
    end

    initial begin
        logic [7:0] pick[4];
        int         n;
        pick = '{8'h00, 8'h20, 8'h40, 8'h60};
        reset = 1'b1; run = 1'b0; symbols = '0; evt.evt_ready = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_active_state", active_state, 0);
        chk("rst_evt_valid", evt.evt_valid, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Start-of-data chain fires once, then expires.
        step(1, 8'h00, 1);
        step(1, 8'h20, 1);
        chk("sod_report", report, 4'b0010);
        chk("sod_evt_valid", evt.evt_valid, 1);
        chk("sod_evt_report", evt.evt_report, 4'b0010);
`ifdef LTL_MON_TIMESTAMP_EN
        chk("sod_evt_idx", evt.evt_idx, 1);
`endif
        step(1, 8'h00, 1);
        step(1, 8'h20, 1);
        chk("sod_expired_report", report, 4'b0000);
        chk("sod_sticky", sticky, 4'b0010);

        // All-input chain fires at any point; sticky survives report dropping.
        step(1, 8'h40, 1);
        step(1, 8'h60, 1);
        chk("all_report", report, 4'b1000);
        step(1, 8'h11, 1);
        chk("all_report_drop", report, 4'b0000);
        chk("all_sticky", sticky, 4'b1010);

        // run low holds the automaton.
        step(1, 8'h40, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 8'h60, 1);
            chk("hold_active", active_state, 4'b0100);
        end
        step(1, 8'h60, 1);
        chk("hold_report", report, 4'b1000);

        // Five events into a depth-4 FIFO with no consumer.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1, 8'h40, 0);
            step(1, 8'h60, 0);
        end
        chk("ovf_set", overflow, 1);
        for (int k = 0; k < 6; k++) step(0, 8'h00, 1);
        chk("ovf_drained", evt.evt_valid, 0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 8'h40, 0);
            step(1, 8'h60, 0);
        end
        chk("full_no_ovf", overflow, 0);
        step(1, 8'h40, 0);
        step(1, 8'h60, 1);
        chk("pushpop_ovf", overflow, 0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (evt.evt_valid) n++;
            step(0, 8'h00, 1);
        end
        chk("pushpop_count", n, 4);

        // Asynchronous reset with two events queued.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            step(1, 8'h40, 0);
            step(1, 8'h60, 0);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_active", active_state, 0);
        chk("arst_report", report, 0);
        chk("arst_sticky", sticky, 0);
        chk("arst_evt_valid", evt.evt_valid, 0);
        chk("arst_overflow", overflow, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(1, 8'h00, 1);
        step(1, 8'h20, 1);
        chk("arst_sod_again", report, 4'b0010);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] s;
            s = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : pick[$urandom_range(0, 3)];
            step($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) == 0);
        end
        for (int k = 0; k < 8; k++) step(0, 8'h00, 1);
        chk("final_drained", evt.evt_valid, 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
